deser_arbiter: RTL and testbench

Round-robin scheduler that shares one `deserializer` instance between `N_REQ` serial requesters. It grants one requester at a time and locks the grant for a full `DATA_W`-bit frame. Accepted bits are forwarded to the deserializer's `data_i`/`data_val_i`. Each parallel word coming back is tagged with the ID of the requester that produced it. The block sits directly in front of the deserializer and drives that instance's reset.

---
 rtl/deser_arb_pkg.sv | 22 ++
 rtl/deser_arbiter_rr_pick.sv | 32 +++
 rtl/deser_arbiter.sv | 160 ++++++++++++++++
 tb/tb_deser_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_arb_pkg.sv
// Shared types and helpers for the deserializer arbiter.
package deser_arb_pkg;

   // Arbiter FSM: IDLE picks the next requester, GRANT holds it for one frame.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Successor of idx in a ring of n entries. The wrap is explicit because
   // n need not be a power of two.
   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      int unsigned nxt;
      if (idx >= n - 32'd1) begin
         nxt = 32'd0;
      end else begin
         nxt = idx + 32'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/deser_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
   import deser_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             found,
   output logic [ID_W-1:0]  id
);

   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1'b1);

   // Walk the ring once starting at ptr; the first active request met wins.
   always_comb begin
      int unsigned idx;
      logic        hit;
      found = 1'b0;
      id    = '0;
      hit   = 1'b0;
      idx   = (32'(ptr) < N_REQ) ? 32'(ptr) : 32'd0;
      for (int k = 0; k < N_REQ; k++) begin
         hit   = (|(req & (ONE_HOT0 << idx))) & ~found;
         id    = hit ? ID_W'(idx) : id;
         found = found | hit;
         idx   = next_idx(idx, N_REQ);
      end
   end

endmodule

// File: rtl/deser_arbiter.sv
// Round-robin scheduler sharing one deserializer between N_REQ serial
// requesters. A grant is locked for a whole DATA_W-bit frame; returning
// parallel words are tagged with the ID of the requester that sent them.
module deser_arbiter
   import deser_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 16,
   parameter int ID_W   = $clog2(N_REQ)
) (
   input  logic              clk_i,
   input  logic              srst_n_i,
   input  logic [N_REQ-1:0]  req_data_i,
   input  logic [N_REQ-1:0]  req_data_val_i,
   output logic [N_REQ-1:0]  req_ready_o,
   output logic              deser_srst_o,
   output logic              deser_data_o,
   output logic              deser_data_val_o,
   input  logic [DATA_W-1:0] deser_word_i,
   input  logic              deser_word_val_i,
   output logic [DATA_W-1:0] word_o,
   output logic [ID_W-1:0]   word_id_o,
   output logic              word_val_o
);

   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [N_REQ-1:0]  ONE_HOT0 = N_REQ'(1'b1);

   state_t            state_r;
   state_t            state_s;
   logic [ID_W-1:0]   grant_id_r;
   logic [ID_W-1:0]   rr_ptr_r;
   logic [ID_W-1:0]   pend_id_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic [N_REQ-1:0]  ready_r;
   logic              pick_found_s;
   logic [ID_W-1:0]   pick_id_s;
   logic              accept_s;
   logic              accept_bit_s;
   logic              frame_end_s;
   logic              deser_data_r;
   logic              deser_data_val_r;
   logic [DATA_W-1:0] word_r;
   logic [ID_W-1:0]   word_id_r;
   logic              word_val_r;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .req   (req_data_val_i),
      .ptr   (rr_ptr_r),
      .found (pick_found_s),
      .id    (pick_id_s)
   );

   // Handshake of the granted requester; ready_r is one-hot only in GRANT.
   always_comb begin
      accept_s     = (state_r == GRANT) && (|(req_data_val_i & ready_r));
      accept_bit_s = |(req_data_i & req_data_val_i & ready_r);
      frame_end_s  = accept_s && (bit_cnt_r == LAST_BIT);
   end

   // Next-state decode; the grant only ends once a full frame is accepted.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (pick_found_s) begin
               state_s = GRANT;
            end else begin
               state_s = IDLE;
            end
         end
         GRANT: begin
            if (frame_end_s) begin
               state_s = IDLE;
            end else begin
               state_s = GRANT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM, grant bookkeeping, bit counter and the registered ready vector.
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_r    <= IDLE;
         grant_id_r <= '0;
         rr_ptr_r   <= '0;
         pend_id_r  <= '0;
         bit_cnt_r  <= '0;
         ready_r    <= '0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (pick_found_s) begin
                  grant_id_r <= pick_id_s;
                  bit_cnt_r  <= '0;
                  ready_r    <= ONE_HOT0 << pick_id_s;
               end else begin
                  ready_r <= '0;
               end
            end
            GRANT: begin
               if (frame_end_s) begin
                  rr_ptr_r  <= ID_W'(next_idx(32'(grant_id_r), N_REQ));
                  pend_id_r <= grant_id_r;
                  ready_r   <= '0;
               end else if (accept_s) begin
                  bit_cnt_r <= bit_cnt_r + CNT_W'(1'b1);
               end
            end
            default: begin
               ready_r <= '0;
            end
         endcase
      end
   end

   // Forward each accepted bit to the deserializer; data holds between bits.
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         deser_data_r     <= 1'b0;
         deser_data_val_r <= 1'b0;
      end else begin
         deser_data_val_r <= accept_s;
         if (accept_s) begin
            deser_data_r <= accept_bit_s;
         end
      end
   end

   // Tag each returning parallel word with the requester that produced it.
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         word_r     <= '0;
         word_id_r  <= '0;
         word_val_r <= 1'b0;
      end else begin
         word_val_r <= deser_word_val_i;
         if (deser_word_val_i) begin
            word_r    <= deser_word_i;
            word_id_r <= pend_id_r;
         end
      end
   end

   assign req_ready_o      = ready_r;
   assign deser_srst_o     = ~srst_n_i;
   assign deser_data_o     = deser_data_r;
   assign deser_data_val_o = deser_data_val_r;
   assign word_o           = word_r;
   assign word_id_o        = word_id_r;
   assign word_val_o       = word_val_r;

endmodule

// File: tb/tb_deser_arbiter.sv
// Self-checking bench for deser_arbiter: a 4-requester instance with a
// deserializer model and scoreboard, plus a 3-requester instance for wrap.
module tb_deser_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- 4-requester instance ----------------
   logic        srst_n;
   logic [3:0]  rval, rdat, rdy;
   logic        dsrst, ddat, dval;
   logic [15:0] dword;
   logic        dword_val;
   logic [15:0] word;
   logic [1:0]  wid;
   logic        wval;

   deser_arbiter #(.N_REQ(4), .DATA_W(16)) dut4 (
      .clk_i(clk), .srst_n_i(srst_n), .req_data_i(rdat), .req_data_val_i(rval),
      .req_ready_o(rdy), .deser_srst_o(dsrst), .deser_data_o(ddat),
      .deser_data_val_o(dval), .deser_word_i(dword), .deser_word_val_i(dword_val),
      .word_o(word), .word_id_o(wid), .word_val_o(wval)
   );

   // ---------------- 3-requester instance ----------------
   logic        srst3_n;
   logic [2:0]  rval3, rdat3, rdy3;
   logic        dsrst3, ddat3, dval3;
   logic [15:0] dword3;
   logic        dword_val3;
   logic [15:0] word3;
   logic [1:0]  wid3;
   logic        wval3;

   deser_arbiter #(.N_REQ(3), .DATA_W(16)) dut3 (
      .clk_i(clk), .srst_n_i(srst3_n), .req_data_i(rdat3), .req_data_val_i(rval3),
      .req_ready_o(rdy3), .deser_srst_o(dsrst3), .deser_data_o(ddat3),
      .deser_data_val_o(dval3), .deser_word_i(dword3), .deser_word_val_i(dword_val3),
      .word_o(word3), .word_id_o(wid3), .word_val_o(wval3)
   );

   // Deserializer models: MSB first, word valid one cycle after the last bit.
   logic [15:0] sh4, sh3;
   int          cnt4, cnt3;
   always @(posedge clk) begin
      if (dsrst) begin
         sh4 <= 16'h0; cnt4 <= 0; dword <= 16'h0; dword_val <= 1'b0;
      end else begin
         dword_val <= 1'b0;
         if (dval) begin
            sh4 <= {sh4[14:0], ddat};
            if (cnt4 == 15) begin
               cnt4 <= 0; dword <= {sh4[14:0], ddat}; dword_val <= 1'b1;
            end else begin
               cnt4 <= cnt4 + 1;
            end
         end
      end
   end
   always @(posedge clk) begin
      if (dsrst3) begin
         sh3 <= 16'h0; cnt3 <= 0; dword3 <= 16'h0; dword_val3 <= 1'b0;
      end else begin
         dword_val3 <= 1'b0;
         if (dval3) begin
            sh3 <= {sh3[14:0], ddat3};
            if (cnt3 == 15) begin
               cnt3 <= 0; dword3 <= {sh3[14:0], ddat3}; dword_val3 <= 1'b1;
            end else begin
               cnt3 <= cnt3 + 1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Requester driver state (4-requester instance)
   logic [15:0] fmem [4][16];
   int          fcnt [4];
   int          fidx [4];
   int          bidx [4];
   bit          gap  [4];
   int          rdy_cnt [4];
   logic [3:0]  acc_pend;
   logic [3:0]  forbid;
   int          bubble_cnt, viol_cnt;
   logic [15:0] exp_word_q [$];
   int          exp_id_q [$];
   int          ord_q [$];
   int          wv_cnt = 0;
   int          wv_cyc [$];

   // Scoreboard: every tagged word must match the oldest completed frame.
   always @(negedge clk) begin
      if (wval) begin
         wv_cnt++;
         wv_cyc.push_back(cyc);
         chk("word_expected", 32'(exp_word_q.size() > 0), 32'd1);
         if (exp_word_q.size() > 0) begin
            chk("word", 32'(word), 32'(exp_word_q.pop_front()));
            chk("word_id", 32'(wid), 32'(exp_id_q.pop_front()));
         end
      end
   end

   // Grant and word capture for the 3-requester instance.
   int          g3_q [$];
   int          w3id_q [$];
   logic [15:0] w3_q [$];
   logic [2:0]  rdy3_prev = 3'b000;
   always @(negedge clk) begin
      if (srst3_n) begin
         if (rdy3 != 3'b000 && rdy3_prev == 3'b000) begin
            for (int i = 0; i < 3; i++) if (rdy3[i]) g3_q.push_back(i);
         end
         if (wval3) begin
            w3id_q.push_back(int'(wid3));
            w3_q.push_back(word3);
         end
      end
      rdy3_prev <= rdy3;
   end

   task automatic clear_driver();
      for (int i = 0; i < 4; i++) begin
         fcnt[i] = 0; fidx[i] = 0; bidx[i] = 0; gap[i] = 1'b0; rdy_cnt[i] = 0;
      end
      rval = 4'b0; rdat = 4'b0; acc_pend = 4'b0; forbid = 4'b0;
      bubble_cnt = 0; viol_cnt = 0;
      exp_word_q.delete(); exp_id_q.delete(); ord_q.delete();
   endtask

   // One clock of requester behaviour, evaluated at the falling edge.
   task automatic cycle();
      logic [15:0] w;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (acc_pend[i]) begin
            bidx[i]++;
            if (bidx[i] == 16) begin
               exp_word_q.push_back(fmem[i][fidx[i]]);
               exp_id_q.push_back(i);
               ord_q.push_back(i);
               fidx[i]++;
               bidx[i] = 0;
            end
         end
         if (acc_pend[i] || !rval[i]) begin
            if (fidx[i] < fcnt[i]) rval[i] = gap[i] ? 1'($urandom_range(0, 1)) : 1'b1;
            else rval[i] = 1'b0;
         end
         if (fidx[i] < fcnt[i]) begin
            w = fmem[i][fidx[i]];
            rdat[i] = w[15 - bidx[i]];
         end else begin
            rdat[i] = 1'b0;
         end
      end
      acc_pend = rval & rdy;
      for (int i = 0; i < 4; i++) if (rdy[i]) rdy_cnt[i]++;
      if (rval != 4'b0 && rdy == 4'b0) bubble_cnt++;
      if ((rdy & forbid) != 4'b0) viol_cnt++;
      if (!$onehot0(rdy)) viol_cnt++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      srst_n = 1'b0;
      clear_driver();
      @(negedge clk);
      @(negedge clk);
      srst_n = 1'b1;
   endtask

   task automatic run_until_done(input int budget);
      int  n;
      bit  busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < budget) begin
         cycle();
         n++;
         busy = (exp_word_q.size() != 0) || (acc_pend != 4'b0);
         for (int i = 0; i < 4; i++) if (fidx[i] < fcnt[i]) busy = 1'b1;
      end
      chk("done_in_budget", 32'(n < budget), 32'd1);
   endtask

   // Table of arbitration scenarios from reset: request mask, frames per
   // requester, expected completion order (nibbles, read left to right).
   typedef struct packed {
      logic [3:0]  mask;
      logic [3:0]  nfr;
      logic [3:0]  nord;
      logic [31:0] ord;
   } vec_t;
   vec_t tbl [5];

   initial begin
      int          n, wv0;
      logic [31:0] ordv;
      int          exp3 [4];

      tbl[0] = '{4'b0100, 4'd1, 4'd1, 32'h2000_0000};
      tbl[1] = '{4'b1111, 4'd2, 4'd8, 32'h0123_0123};
      tbl[2] = '{4'b1001, 4'd3, 4'd6, 32'h0303_0300};
      tbl[3] = '{4'b0110, 4'd2, 4'd4, 32'h1212_0000};
      tbl[4] = '{4'b1010, 4'd2, 4'd4, 32'h1313_0000};
      exp3 = '{0, 2, 0, 2};

      srst_n = 1'b0; srst3_n = 1'b0;
      rval3 = 3'b000; rdat3 = 3'b001;
      clear_driver();

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(rdy), 32'd0);
      chk("rst_deser_data", 32'(ddat), 32'd0);
      chk("rst_deser_val", 32'(dval), 32'd0);
      chk("rst_word", 32'(word), 32'd0);
      chk("rst_word_id", 32'(wid), 32'd0);
      chk("rst_word_val", 32'(wval), 32'd0);
      chk("rst_deser_srst", 32'(dsrst), 32'd1);
      srst_n = 1'b1;
      #1 chk("deser_srst_released", 32'(dsrst), 32'd0);

      // Table-driven arbitration scenarios
      for (int t = 0; t < 5; t++) begin
         do_reset();
         for (int i = 0; i < 4; i++) begin
            if (tbl[t].mask[i]) begin
               fcnt[i] = int'(tbl[t].nfr);
               for (int f = 0; f < 16; f++) fmem[i][f] = (t == 0) ? 16'hA5C3 : 16'($urandom);
            end
         end
         run_until_done(3000);
         chk("order_len", 32'(ord_q.size()), 32'(tbl[t].nord));
         ordv = tbl[t].ord;
         for (int k = 0; k < int'(tbl[t].nord); k++) begin
            chk("grant_order", (k < ord_q.size()) ? 32'(ord_q[k]) : 32'd99, 32'(ordv[31 - 4*k -: 4]));
         end
         for (int i = 0; i < 4; i++) begin
            chk("ready_cycles", 32'(rdy_cnt[i]), tbl[t].mask[i] ? 32'(16 * int'(tbl[t].nfr)) : 32'd0);
         end
         chk("idle_bubbles", 32'(bubble_cnt), 32'(tbl[t].nord));
         chk("ready_onehot", 32'(viol_cnt), 32'd0);
      end

      // Gapped frame: requester 1 at 50% valid keeps the grant for 16 bits
      do_reset();
      gap[1] = 1'b1;
      fcnt[1] = 2;
      fmem[1][0] = 16'h9E71;
      fmem[1][1] = 16'h0F0F;
      n = 0;
      while (!rdy[1] && n < 200) begin cycle(); n++; end
      chk("gap_grant_seen", 32'(rdy[1]), 32'd1);
      fcnt[0] = 1; fmem[0][0] = 16'h1234;
      fcnt[2] = 1; fmem[2][0] = 16'hBEEF;
      fcnt[3] = 1; fmem[3][0] = 16'h8001;
      forbid = 4'b1101;
      n = 0;
      while (fidx[1] == 0 && n < 2000) begin cycle(); n++; end
      forbid = 4'b0000;
      chk("gap_frame_done", 32'(fidx[1]), 32'd1);
      chk("gap_foreign_ready", 32'(viol_cnt), 32'd0);
      run_until_done(3000);
      chk("gap_order_len", 32'(ord_q.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         ordv = 32'h1230_1000;
         chk("gap_order", (k < ord_q.size()) ? 32'(ord_q[k]) : 32'd99, 32'(ordv[31 - 4*k -: 4]));
      end

      // Throughput: 10 back-to-back frames from one requester
      do_reset();
      fcnt[1] = 10;
      for (int f = 0; f < 10; f++) fmem[1][f] = 16'($urandom) | 16'h0001;
      wv_cyc.delete();
      run_until_done(3000);
      chk("stream_words", 32'(wv_cyc.size()), 32'd10);
      for (int k = 1; k < wv_cyc.size(); k++) begin
         chk("word_period", 32'(wv_cyc[k] - wv_cyc[k-1]), 32'd17);
      end

      // Reset after 7 bits of a frame from requester 0
      fcnt[0] = 1; fidx[0] = 0; bidx[0] = 0;
      fmem[0][0] = 16'hFE01;
      n = 0;
      while (bidx[0] < 7 && n < 200) begin cycle(); n++; end
      chk("midframe_bits", 32'(bidx[0]), 32'd7);
      srst_n = 1'b0;
      clear_driver();
      #1 chk("midframe_deser_srst", 32'(dsrst), 32'd1);
      @(negedge clk);
      chk("midframe_ready", 32'(rdy), 32'd0);
      chk("midframe_deser_data", 32'(ddat), 32'd0);
      chk("midframe_deser_val", 32'(dval), 32'd0);
      chk("midframe_word", 32'(word), 32'd0);
      chk("midframe_word_id", 32'(wid), 32'd0);
      chk("midframe_word_val", 32'(wval), 32'd0);
      wv0 = wv_cnt;
      @(negedge clk);
      srst_n = 1'b1;
      repeat (40) cycle();
      chk("no_stale_word", 32'(wv_cnt - wv0), 32'd0);
      fcnt[0] = 1;
      fmem[0][0] = 16'h5A3C;
      run_until_done(500);
      chk("after_reset_words", 32'(wv_cnt - wv0), 32'd1);

      // Wrap with N_REQ = 3: requesters 0 and 2 alternate
      @(negedge clk);
      srst3_n = 1'b1;
      rval3 = 3'b101;
      repeat (100) @(negedge clk);
      rval3 = 3'b000;
      for (int k = 0; k < 4; k++) begin
         chk("n3_grant_order", (k < g3_q.size()) ? 32'(g3_q[k]) : 32'd99, 32'(exp3[k]));
         chk("n3_word_id", (k < w3id_q.size()) ? 32'(w3id_q[k]) : 32'd99, 32'(exp3[k]));
         chk("n3_word", (k < w3_q.size()) ? 32'(w3_q[k]) : 32'hDEAD_0000,
             (exp3[k] == 0) ? 32'h0000_FFFF : 32'h0000_0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard stop in case the run never reaches its summary.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
